// File: rtl/mma_sequencer_pkg.sv
// Shared types and constants for the MMA tile sequencer and its systolic array.
package mma_sequencer_pkg;

  localparam int unsigned MMA_M        = 1;
  localparam int unsigned MMA_K        = 8;
  // Array latency the sequencer must match; change both sides together.
  localparam int unsigned MMA_PIPE_LAT = 5;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } mma_seq_state_t;

  // Column count needs to represent 0..n_max inclusive.
  function automatic int unsigned mma_col_w(input int unsigned n_max);
    return $clog2(n_max) + 1;
  endfunction

endpackage

// File: rtl/mma_sequencer_if.sv
// Command, buffer-access and status bundle between the MMA front-end and the sequencer.
interface mma_sequencer_if import mma_sequencer_pkg::*; #(
  parameter int unsigned N_MAX  = 64,
  parameter int unsigned ADDR_W = 8
) ();

  localparam int unsigned CW = mma_col_w(N_MAX);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CW-1:0]     cmd_n;
  logic [ADDR_W-1:0] cmd_b_base;
  logic [ADDR_W-1:0] cmd_c_base;
  logic [ADDR_W-1:0] cmd_d_base;
  logic              hold;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_b_addr;
  logic [ADDR_W-1:0] rd_c_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;
  logic              done;
  logic              err_in;
  logic              clr_err;
  logic              err_sticky;

  modport master (
    output cmd_valid, cmd_n, cmd_b_base, cmd_c_base, cmd_d_base, hold, err_in, clr_err,
    input  cmd_ready, rd_en, rd_b_addr, rd_c_addr, wr_en, wr_addr, busy, done, err_sticky
  );

  modport slave (
    input  cmd_valid, cmd_n, cmd_b_base, cmd_c_base, cmd_d_base, hold, err_in, clr_err,
    output cmd_ready, rd_en, rd_b_addr, rd_c_addr, wr_en, wr_addr, busy, done, err_sticky
  );

endinterface

// File: rtl/mma_sequencer_valid_delay_line.sv
// Fixed-depth shift register carrying a valid flag plus payload; every stage is visible.
module valid_delay_line #(
  parameter int unsigned Depth = 6,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [Width-1:0] i_data,
  output logic             o_valid,
  output logic [Width-1:0] o_data,
  output logic [Depth-1:0] o_valid_vec
);

  logic [Depth-1:0] r_valid;
  logic [Width-1:0] r_data [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < Depth; i++) r_data[i] <= '0;
    end else begin
      r_valid <= {r_valid[Depth-2:0], i_valid};
      r_data[0] <= i_data;
      for (int i = 1; i < Depth; i++) r_data[i] <= r_data[i-1];
    end
  end

  assign o_valid     = r_valid[Depth-1];
  assign o_data      = r_data[Depth-1];
  assign o_valid_vec = r_valid;

endmodule

// File: rtl/mma_sequencer.sv
// Job sequencer for the systolic MMA tile: issues operand reads one column per cycle and
// tracks each column through the array latency to drive result writes and job completion.
module mma_sequencer import mma_sequencer_pkg::*; #(
  parameter int unsigned M_MMA    = MMA_M,
  parameter int unsigned K_MMA    = MMA_K,
  parameter int unsigned N_MAX    = 64,
  parameter int unsigned PIPE_LAT = MMA_PIPE_LAT,
  parameter int unsigned ADDR_W   = 8
) (
  input logic            clk,
  input logic            rst_n,
  mma_sequencer_if.slave bus
);

  localparam int unsigned CW    = mma_col_w(N_MAX);
  localparam int unsigned Depth = PIPE_LAT + 1;

  if (PIPE_LAT == 0 || K_MMA == 0 || M_MMA == 0) begin : g_param_check
    $error("mma_sequencer: M_MMA, K_MMA and PIPE_LAT must be nonzero");
  end

  mma_seq_state_t    r_state, w_state_next;
  logic [CW-1:0]     r_n, w_n_next, r_col, w_col_next, w_n_clamped;
  logic [ADDR_W-1:0] r_b_base, w_b_base_next, r_c_base, w_c_base_next, r_d_base, w_d_base_next;
  logic [ADDR_W-1:0] r_rd_b_addr, w_rd_b_next, r_rd_c_addr, w_rd_c_next;
  logic [ADDR_W-1:0] r_issue_addr, w_issue_addr_next, w_tail_addr;
  logic              r_rd_en, w_rd_en_next, r_done, w_done_next, r_busy, r_err, w_err_next;
  logic              w_tail_valid;
  logic [Depth-1:0]  w_valid_vec, w_upstream;

  assign w_n_clamped = (bus.cmd_n > CW'(N_MAX)) ? CW'(N_MAX) : bus.cmd_n;
  // Stages that cannot reach the tail within one cycle; empty means this edge ends the job.
  assign w_upstream  = w_valid_vec << 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_n          <= '0;
      r_col        <= '0;
      r_b_base     <= '0;
      r_c_base     <= '0;
      r_d_base     <= '0;
      r_rd_en      <= 1'b0;
      r_rd_b_addr  <= '0;
      r_rd_c_addr  <= '0;
      r_issue_addr <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_n          <= w_n_next;
      r_col        <= w_col_next;
      r_b_base     <= w_b_base_next;
      r_c_base     <= w_c_base_next;
      r_d_base     <= w_d_base_next;
      r_rd_en      <= w_rd_en_next;
      r_rd_b_addr  <= w_rd_b_next;
      r_rd_c_addr  <= w_rd_c_next;
      r_issue_addr <= w_issue_addr_next;
      r_done       <= w_done_next;
      r_busy       <= (w_state_next != StIdle);
      r_err        <= w_err_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_n_next          = r_n;
    w_col_next        = r_col;
    w_b_base_next     = r_b_base;
    w_c_base_next     = r_c_base;
    w_d_base_next     = r_d_base;
    w_rd_en_next      = 1'b0;
    w_rd_b_next       = r_rd_b_addr;
    w_rd_c_next       = r_rd_c_addr;
    w_issue_addr_next = r_issue_addr;
    w_done_next       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.cmd_valid) begin
          w_n_next      = w_n_clamped;
          w_col_next    = '0;
          w_b_base_next = bus.cmd_b_base;
          w_c_base_next = bus.cmd_c_base;
          w_d_base_next = bus.cmd_d_base;
          w_state_next  = (w_n_clamped == '0) ? StDrain : StIssue;
        end
      end
      StIssue: begin
        if (!bus.hold) begin
          w_rd_en_next      = 1'b1;
          w_rd_b_next       = r_b_base + ADDR_W'(r_col);
          w_rd_c_next       = r_c_base + ADDR_W'(r_col);
          w_issue_addr_next = r_d_base + ADDR_W'(r_col) * ADDR_W'(M_MMA);
          w_col_next        = r_col + CW'(1);
          if (r_col == r_n - CW'(1)) w_state_next = StDrain;
        end
      end
      StDrain: begin
        w_done_next = !r_done && !r_rd_en && (w_upstream == '0);
        if (r_done) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase

    if (bus.err_in && (w_valid_vec != '0)) w_err_next = 1'b1;
    else if (bus.clr_err)                  w_err_next = 1'b0;
    else                                   w_err_next = r_err;
  end

  // Fed from the registered read strobe, so stage 0 lines up with data at the array inputs.
  valid_delay_line #(
    .Depth(Depth),
    .Width(ADDR_W)
  ) u_track (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (r_rd_en),
    .i_data     (r_issue_addr),
    .o_valid    (w_tail_valid),
    .o_data     (w_tail_addr),
    .o_valid_vec(w_valid_vec)
  );

  assign bus.cmd_ready  = (r_state == StIdle);
  assign bus.rd_en      = r_rd_en;
  assign bus.rd_b_addr  = r_rd_b_addr;
  assign bus.rd_c_addr  = r_rd_c_addr;
  assign bus.wr_en      = w_tail_valid;
  assign bus.wr_addr    = w_tail_addr;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err_sticky = r_err;

endmodule
